// File: rtl/sv_add_pipe_if.sv
// Handshake and data bundle for the multi-lane pipelined adder.
// The adder is the slave; whatever feeds it and drains it is the master.
interface sv_add_pipe_if #(
    parameter int LANES = 4,
    parameter int AW    = 9,
    parameter int BW    = 6,
    parameter int OW    = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_signed;
    logic [LANES*AW-1:0]   in_a;
    logic [LANES*BW-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*OW-1:0]   out_sum;
    logic [LANES-1:0]      out_ovf;

    modport master (
        output in_valid, in_signed, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/sv_add_pipe.sv
// Two-stage, multi-lane adder with SystemVerilog '+' extension rules,
// per-lane overflow flags, optional saturation and valid/ready flow control.
module sv_add_pipe #(
    parameter int LANES = 4,
    parameter int AW    = 9,
    parameter int BW    = 6,
    parameter int OW    = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    sv_add_pipe_if.slave bus
);
    localparam int MW = (AW > BW) ? AW : BW;
    localparam int EW = ((MW > OW) ? MW : OW) + 1;

    logic [LANES-1:0][EW-1:0] a_ext_q, a_ext_d;
    logic [LANES-1:0][EW-1:0] b_ext_q, b_ext_d;
    logic                     sgn_q, sgn_d;
    logic                     s1_valid_q, s1_valid_d;

    logic [LANES*OW-1:0]      sum_q, sum_d;
    logic [LANES-1:0]         ovf_q, ovf_d;
    logic                     s2_valid_q, s2_valid_d;

    logic                     s2_load;
    logic                     s1_advance;
    logic                     in_ready;
    logic                     in_fire;

    logic [EW-1:0]            lane_s;
    logic [EW-OW:0]           lane_top;
    logic                     lane_ovf;
    logic [OW-1:0]            lane_sum;

    // in_ready is gated by rst_n so it reads 0 during reset and 1 right after release
    always_comb begin
        s2_load    = !s2_valid_q || bus.out_ready;
        s1_advance = s1_valid_q && s2_load;
        in_ready   = rst_n && (!s1_valid_q || s1_advance);
        in_fire    = bus.in_valid && in_ready;
    end

    always_comb begin
        a_ext_d    = a_ext_q;
        b_ext_d    = b_ext_q;
        sgn_d      = sgn_q;
        s1_valid_d = s1_valid_q;
        if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            sgn_d      = bus.in_signed;
            for (int i = 0; i < LANES; i++) begin
                a_ext_d[i] = {{(EW-AW){bus.in_signed & bus.in_a[i*AW+AW-1]}}, bus.in_a[i*AW +: AW]};
                b_ext_d[i] = {{(EW-BW){bus.in_signed & bus.in_b[i*BW+BW-1]}}, bus.in_b[i*BW +: BW]};
            end
        end
    end

    // EW exceeds every operand and result width, so lane_s is exact; the bits
    // from OW-1 upward must all match for a signed result to fit in OW bits
    always_comb begin
        sum_d      = sum_q;
        ovf_d      = ovf_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        lane_s     = '0;
        lane_top   = '0;
        lane_ovf   = 1'b0;
        lane_sum   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_s   = a_ext_q[i] + b_ext_q[i];
            lane_top = lane_s[EW-1:OW-1];
            if (sgn_q) begin
                lane_ovf = !((&lane_top) || !(|lane_top));
            end else begin
                lane_ovf = |lane_s[EW-1:OW];
            end
            lane_sum = lane_s[OW-1:0];
            if (SAT && lane_ovf) begin
                if (!sgn_q) begin
                    lane_sum = '1;
                end else if (lane_s[EW-1]) begin
                    lane_sum = {1'b1, {(OW-1){1'b0}}};
                end else begin
                    lane_sum = {1'b0, {(OW-1){1'b1}}};
                end
            end
            if (s1_advance) begin
                sum_d[i*OW +: OW] = lane_sum;
                ovf_d[i]          = lane_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ext_q    <= '0;
            b_ext_q    <= '0;
            sgn_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            sum_q      <= '0;
            ovf_q      <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            a_ext_q    <= a_ext_d;
            b_ext_q    <= b_ext_d;
            sgn_q      <= sgn_d;
            s1_valid_q <= s1_valid_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_sv_add_pipe.sv
// Directed bench: two 2-lane/4-bit adders (wrap and saturate) fed identically,
// plus a 1-lane/16-bit adder for the wide-result extension cases.
module tb_sv_add_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sv_add_pipe_if #(.LANES(2), .AW(9), .BW(6), .OW(4))  bw ();
    sv_add_pipe_if #(.LANES(2), .AW(9), .BW(6), .OW(4))  bs ();
    sv_add_pipe_if #(.LANES(1), .AW(9), .BW(6), .OW(16)) b16 ();

    sv_add_pipe #(.LANES(2), .AW(9), .BW(6), .OW(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bw));
    sv_add_pipe #(.LANES(2), .AW(9), .BW(6), .OW(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bs));
    sv_add_pipe #(.LANES(1), .AW(9), .BW(6), .OW(16), .SAT(1'b0)) u_wide (
        .clk(clk), .rst_n(rst_n), .bus(b16));

    assign bs.in_valid  = bw.in_valid;
    assign bs.in_signed = bw.in_signed;
    assign bs.in_a      = bw.in_a;
    assign bs.in_b      = bw.in_b;
    assign bs.out_ready = bw.out_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat2(input string tag, input logic sgn, input logic [17:0] a,
                         input logic [11:0] b, input logic [7:0] exp_w,
                         input logic [7:0] exp_s, input logic [1:0] exp_ovf);
        int n;
        @(negedge clk);
        bw.in_signed = sgn;
        bw.in_a      = a;
        bw.in_b      = b;
        bw.in_valid  = 1'b1;
        bw.out_ready = 1'b1;
        #1;
        n = 0;
        while (!bw.in_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_accept"}, 32'(n < 10), 32'd1);
        @(negedge clk);
        bw.in_valid = 1'b0;
        n = 0;
        while (!bw.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 1);
        chk({tag, "_sum_wrap"}, bw.out_sum, exp_w);
        chk({tag, "_sum_sat"}, bs.out_sum, exp_s);
        chk({tag, "_ovf_wrap"}, bw.out_ovf, exp_ovf);
        chk({tag, "_ovf_sat"}, bs.out_ovf, exp_ovf);
    endtask

    task automatic beat16(input string tag, input logic sgn, input logic [8:0] a,
                          input logic [5:0] b, input logic [15:0] exp_sum, input logic exp_ovf);
        int n;
        @(negedge clk);
        b16.in_signed = sgn;
        b16.in_a      = a;
        b16.in_b      = b;
        b16.in_valid  = 1'b1;
        b16.out_ready = 1'b1;
        #1;
        n = 0;
        while (!b16.in_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        b16.in_valid = 1'b0;
        n = 0;
        while (!b16.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 1);
        chk({tag, "_sum"}, b16.out_sum, exp_sum);
        chk({tag, "_ovf"}, b16.out_ovf, exp_ovf);
    endtask

    task automatic run_stream();
        int   tx, rx, acc_at_low, first_out;
        logic seen_low;
        tx = 1; rx = 1; acc_at_low = -1; first_out = -1; seen_low = 1'b0;
        bw.in_signed = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bw.out_ready = !(cyc >= 3 && cyc <= 6);
            bw.in_valid  = (tx <= 8);
            bw.in_a      = {9'(tx), 9'(tx)};
            bw.in_b      = {6'd1, 6'd0};
            #1;
            if (!bw.in_ready && !seen_low) begin
                seen_low   = 1'b1;
                acc_at_low = tx - 1;
            end
            if (bw.out_valid) begin
                if (first_out < 0) first_out = cyc;
                chk("stream_sum", bw.out_sum, {4'(rx + 1), 4'(rx)});
                chk("stream_ovf", bw.out_ovf, 2'b00);
                if (bw.out_ready) rx++;
            end
            if (bw.in_valid && bw.in_ready) tx++;
        end
        bw.in_valid = 1'b0;
        chk("stream_rx_count", rx - 1, 8);
        chk("stream_tx_count", tx - 1, 8);
        chk("stream_ready_fall", acc_at_low, 2);
        chk("stream_first_out", first_out, 3);
    endtask

    task automatic run_reset_flight();
        logic stale;
        @(negedge clk);
        bw.out_ready = 1'b0;
        bw.in_signed = 1'b0;
        bw.in_valid  = 1'b1;
        bw.in_a      = {9'd2, 9'd3};
        bw.in_b      = {6'd1, 6'd1};
        @(negedge clk);
        bw.in_a      = {9'd4, 9'd5};
        @(negedge clk);
        bw.in_valid  = 1'b0;
        chk("flight_out_valid", bw.out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bw.out_valid, 0);
        chk("rst_in_ready", bw.in_ready, 0);
        chk("rst_out_sum", bw.out_sum, 8'h00);
        chk("rst_out_ovf", bw.out_ovf, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", bw.in_ready, 1);
        chk("release_out_valid", bw.out_valid, 0);
        bw.out_ready = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bw.out_valid) stale = 1'b1;
        end
        chk("no_stale_beat", stale, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bw.in_valid   = 1'b0;
        bw.in_signed  = 1'b0;
        bw.in_a       = '0;
        bw.in_b       = '0;
        bw.out_ready  = 1'b1;
        b16.in_valid  = 1'b0;
        b16.in_signed = 1'b0;
        b16.in_a      = '0;
        b16.in_b      = '0;
        b16.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", bw.out_valid, 0);
        chk("reset_in_ready", bw.in_ready, 0);
        chk("reset_out_sum", bw.out_sum, 8'h00);
        chk("reset_out_ovf", bw.out_ovf, 2'b00);
        chk("reset_sat_out_valid", bs.out_valid, 0);
        chk("reset_wide_out_sum", b16.out_sum, 16'h0000);
        #2 rst_n = 1'b1;
        #1;
        chk("first_cycle_in_ready", bw.in_ready, 1);
        chk("first_cycle_wide_ready", b16.in_ready, 1);

        // lane1 carries a separate small case on every vector
        beat2("u_carry_out",  1'b0, {9'h003, 9'h1FF}, {6'h04, 6'h01}, 8'h70, 8'h7F, 2'b01);
        beat2("s_neg_neg",    1'b1, {9'h005, 9'h1FF}, {6'h3E, 6'h3F}, 8'h3E, 8'h3E, 2'b00);
        beat2("s_pos_ovf",    1'b1, {9'h1F8, 9'h0FF}, {6'h00, 6'h01}, 8'h80, 8'h87, 2'b01);
        beat2("s_neg_ovf",    1'b1, {9'h007, 9'h100}, {6'h01, 6'h20}, 8'h80, 8'h78, 2'b11);
        beat2("u_edge",       1'b0, {9'h00F, 9'h00F}, {6'h01, 6'h00}, 8'h0F, 8'hFF, 2'b10);

        beat16("wide_unsigned", 1'b0, 9'h1FF, 6'h3F, 16'h023E, 1'b0);
        beat16("wide_signed",   1'b1, 9'h1FF, 6'h3F, 16'hFFFE, 1'b0);

        run_stream();
        run_reset_flight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
